sflash_ctrl: RTL and testbench

SFLASH_CTRL -- requirements
Module: sflash_ctrl

---
 rtl/sflash_ctrl_pkg.sv | 26 ++
 rtl/sflash_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sflash_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sflash_ctrl_pkg.sv
// Shared encodings for the serial-flash read controller: engine format codes,
// read opcodes, the quad mode byte and the controller state encoding.
package sflash_ctrl_pkg;

    // eng_format codes; 000/001 deassert CS#
    localparam logic [2:0] FMT_IDLE  = 3'b000;
    localparam logic [2:0] FMT_CMD   = 3'b010;
    localparam logic [2:0] FMT_SDATA = 3'b011;
    localparam logic [2:0] FMT_QADDR = 3'b110;
    localparam logic [2:0] FMT_QDATA = 3'b111;

    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_QUAD_READ = 8'hEB;
    localparam logic [7:0] MODE_BYTE    = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_CSHI
    } state_t;

endpackage

// File: rtl/sflash_ctrl.sv
// Serial-flash read controller: sequences fast-read / quad-read transactions
// byte by byte over an external byte engine and buffers one received byte.
module sflash_ctrl
    import sflash_ctrl_pkg::*;
#(
    parameter int         CSH_CYCLES = 4,
    parameter logic [7:0] DATA_OUT   = 8'hFF
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        req,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    input  logic        quad,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic        eng_ready,
    output logic        eng_wr,
    output logic [7:0]  eng_din,
    output logic [2:0]  eng_format,
    input  logic [7:0]  eng_dout
);

    localparam int CW = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES) : 1;

    state_t        state;
    logic [23:0]   addr_q;
    logic [15:0]   dcnt;
    logic          quad_q;
    logic [1:0]    bcnt;
    logic          skip;
    logic          abort_seen;
    logic          pend;
    logic [CW-1:0] csh_cnt;

    logic byte_done, buf_free, stop;

    // the engine's ready is not trusted in the cycle right after a write
    assign byte_done = !eng_wr && !skip && eng_ready;
    assign buf_free  = !rd_valid || rd_ready;
    assign stop      = abort_seen || abort;

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            eng_wr     <= 1'b0;
            eng_din    <= 8'h00;
            eng_format <= FMT_IDLE;
            rd_valid   <= 1'b0;
            rd_data    <= 8'h00;
            addr_q     <= '0;
            dcnt       <= '0;
            quad_q     <= 1'b0;
            bcnt       <= '0;
            skip       <= 1'b0;
            abort_seen <= 1'b0;
            pend       <= 1'b0;
            csh_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (eng_wr) begin
                eng_wr <= 1'b0;
                skip   <= 1'b1;
            end else if (skip) begin
                skip <= 1'b0;
            end
            if (rd_valid && rd_ready)
                rd_valid <= 1'b0;
            if (abort && state != ST_IDLE && state != ST_CSHI)
                abort_seen <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (req && eng_ready) begin
                        addr_q     <= addr;
                        dcnt       <= len;
                        quad_q     <= quad;
                        busy       <= 1'b1;
                        abort_seen <= 1'b0;
                        state      <= ST_CMD;
                        eng_wr     <= 1'b1;
                        eng_din    <= quad ? OP_QUAD_READ : OP_FAST_READ;
                        eng_format <= FMT_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        if (stop) begin
                            state <= ST_CSHI; eng_format <= FMT_IDLE; csh_cnt <= '0;
                        end else begin
                            state      <= ST_ADDR;
                            bcnt       <= 2'd1;
                            eng_wr     <= 1'b1;
                            eng_din    <= addr_q[23:16];
                            eng_format <= quad_q ? FMT_QADDR : FMT_CMD;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        if (stop) begin
                            state <= ST_CSHI; eng_format <= FMT_IDLE; csh_cnt <= '0;
                        end else if (bcnt != 2'd3) begin
                            // bcnt counts address bytes already issued, MSB first
                            eng_wr  <= 1'b1;
                            eng_din <= (bcnt == 2'd1) ? addr_q[15:8] : addr_q[7:0];
                            bcnt    <= bcnt + 2'd1;
                        end else if (quad_q) begin
                            state   <= ST_MODE;
                            eng_wr  <= 1'b1;
                            eng_din <= MODE_BYTE;
                        end else begin
                            state      <= ST_DUMMY;
                            bcnt       <= 2'd1;
                            eng_wr     <= 1'b1;
                            eng_din    <= DATA_OUT;
                            eng_format <= FMT_SDATA;
                        end
                    end
                end
                ST_MODE: begin
                    if (byte_done) begin
                        if (stop) begin
                            state <= ST_CSHI; eng_format <= FMT_IDLE; csh_cnt <= '0;
                        end else begin
                            state      <= ST_DUMMY;
                            bcnt       <= 2'd1;
                            eng_wr     <= 1'b1;
                            eng_din    <= DATA_OUT;
                            eng_format <= FMT_QDATA;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (byte_done) begin
                        if (stop || dcnt == 16'd0) begin
                            state <= ST_CSHI; eng_format <= FMT_IDLE; csh_cnt <= '0;
                        end else if (quad_q && bcnt == 2'd1) begin
                            bcnt    <= 2'd2;
                            eng_wr  <= 1'b1;
                            eng_din <= DATA_OUT;
                        end else begin
                            state <= ST_DATA;
                            pend  <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // pend: no byte in flight, next one waits for buffer space
                    if (pend) begin
                        if (stop) begin
                            state <= ST_CSHI; eng_format <= FMT_IDLE; csh_cnt <= '0;
                            pend  <= 1'b0;
                        end else if (buf_free) begin
                            pend    <= 1'b0;
                            eng_wr  <= 1'b1;
                            eng_din <= DATA_OUT;
                        end
                    end else if (byte_done) begin
                        rd_data  <= eng_dout;
                        rd_valid <= 1'b1;
                        if (dcnt != 16'd0)
                            dcnt <= dcnt - 16'd1;
                        if (stop || dcnt <= 16'd1) begin
                            state <= ST_CSHI; eng_format <= FMT_IDLE; csh_cnt <= '0;
                        end else begin
                            pend <= 1'b1;
                        end
                    end
                end
                ST_CSHI: begin
                    if (csh_cnt == CW'(CSH_CYCLES - 1)) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        csh_cnt <= '0;
                    end else begin
                        csh_cnt <= csh_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sflash_ctrl.sv
// Directed bench for sflash_ctrl with a small byte-engine model (fixed latency,
// dout = 8'h3C + 7*write_index) and event logs checked after each transaction.
module tb_sflash_ctrl;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        req = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] len = '0;
    logic        quad = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, rd_valid, eng_wr;
    logic [7:0]  rd_data, eng_din;
    logic [2:0]  eng_format;
    logic        rd_ready = 1'b1;
    logic        eng_ready = 1'b1;
    logic [7:0]  eng_dout = 8'h00;

    int checks = 0;
    int errors = 0;

    sflash_ctrl dut (
        .clk(clk), .arstn(arstn), .req(req), .addr(addr), .len(len), .quad(quad),
        .abort(abort), .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .eng_ready(eng_ready), .eng_wr(eng_wr), .eng_din(eng_din),
        .eng_format(eng_format), .eng_dout(eng_dout)
    );

    always #5 clk = ~clk;

    // event logs, cleared by pulsing clr
    logic       clr = 1'b0;
    int         nwr = 0, nrd = 0, ndone = 0, ncsh = 0, nrv = 0, nviol = 0;
    logic [7:0] din_log [0:31];
    logic [2:0] fmt_log [0:31];
    logic [7:0] rd_log  [0:31];

    always @(posedge clk) begin
        if (clr) begin
            nwr <= 0; nrd <= 0; ndone <= 0; ncsh <= 0; nrv <= 0; nviol <= 0;
        end else begin
            if (eng_wr && nwr < 32) begin
                din_log[nwr] <= eng_din;
                fmt_log[nwr] <= eng_format;
                nwr <= nwr + 1;
            end
            if (rd_valid && rd_ready && nrd < 32) begin
                rd_log[nrd] <= rd_data;
                nrd <= nrd + 1;
            end
            if (done) ndone <= ndone + 1;
            if (busy && eng_format == 3'b000) ncsh <= ncsh + 1;
            if (rd_valid) nrv <= nrv + 1;
            if (eng_wr && rd_valid && !rd_ready) nviol <= nviol + 1;
        end
    end

    // byte engine: ready drops after a write, returns two cycles later with data
    int lat = 0;
    int cur_k = 0;
    always @(posedge clk) begin
        if (eng_wr) begin
            eng_ready <= 1'b0;
            lat       <= 2;
            cur_k     <= nwr;
        end else if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                eng_ready <= 1'b1;
                eng_dout  <= 8'(8'h3C + 7 * cur_k);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic start_read(input logic [23:0] a, input logic [15:0] l, input logic q);
        @(negedge clk);
        req = 1'b1; addr = a; len = l; quad = q;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_nwr(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (nwr >= n) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    logic [7:0] exp_fast_din [0:7] = '{8'h0B, 8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [2:0] exp_fast_fmt [0:7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011};
    logic [2:0] exp_quad_fmt [0:8] = '{3'b010, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b111, 3'b111};
    logic [7:0] exp_quad_din [0:8] = '{8'hEB, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_rd [0:3] = '{8'h5F, 8'h66, 8'h6D, 8'h74};
    logic [7:0] exp_rst_din [0:5] = '{8'h0B, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF};

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_eng_wr", 32'(eng_wr), 32'd0);
        chk("rst_format", 32'(eng_format), 32'd0);
        chk("rst_din", 32'(eng_din), 32'h00);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        arstn = 1'b1;
        clear_log();

        // fast read, 3 bytes
        start_read(24'h123456, 16'd3, 1'b0);
        chk("fast_busy", 32'(busy), 32'd1);
        wait_done("fast_done_seen");
        chk("fast_nwr", 32'(nwr), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fast_din%0d", i), 32'(din_log[i]), 32'(exp_fast_din[i]));
            chk($sformatf("fast_fmt%0d", i), 32'(fmt_log[i]), 32'(exp_fast_fmt[i]));
        end
        chk("fast_nrd", 32'(nrd), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("fast_rd%0d", i), 32'(rd_log[i]), 32'(exp_rd[i]));
        chk("fast_ndone", 32'(ndone), 32'd1);
        chk("fast_cshi", 32'(ncsh), 32'd4);
        chk("fast_busy_end", 32'(busy), 32'd0);

        // quad read, 2 bytes
        clear_log();
        start_read(24'h000000, 16'd2, 1'b1);
        wait_done("quad_done_seen");
        chk("quad_nwr", 32'(nwr), 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("quad_fmt%0d", i), 32'(fmt_log[i]), 32'(exp_quad_fmt[i]));
            chk($sformatf("quad_din%0d", i), 32'(din_log[i]), 32'(exp_quad_din[i]));
        end
        chk("quad_nrd", 32'(nrd), 32'd2);
        chk("quad_rd0", 32'(rd_log[0]), 32'h6D);
        chk("quad_rd1", 32'(rd_log[1]), 32'h74);
        chk("quad_ndone", 32'(ndone), 32'd1);

        // len = 0
        clear_log();
        start_read(24'hABCDEF, 16'd0, 1'b0);
        wait_done("len0_done_seen");
        chk("len0_nwr", 32'(nwr), 32'd5);
        chk("len0_last_fmt", 32'(fmt_log[4]), 32'(3'b011));
        chk("len0_nrv", 32'(nrv), 32'd0);
        chk("len0_cshi", 32'(ncsh), 32'd4);
        chk("len0_ndone", 32'(ndone), 32'd1);

        // consumer stall for 20 cycles during DATA
        clear_log();
        rd_ready = 1'b0;
        start_read(24'hABCDEF, 16'd4, 1'b0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                if (rd_valid) seen = 1'b1;
            end
            chk("stall_rv_seen", 32'(seen), 32'd1);
        end
        repeat (20) @(negedge clk);
        chk("stall_nwr", 32'(nwr), 32'd6);
        chk("stall_rd_data", 32'(rd_data), 32'h5F);
        chk("stall_rd_valid", 32'(rd_valid), 32'd1);
        rd_ready = 1'b1;
        wait_done("stall_done_seen");
        chk("stall_nviol", 32'(nviol), 32'd0);
        chk("stall_nrd", 32'(nrd), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stall_rd%0d", i), 32'(rd_log[i]), 32'(exp_rd[i]));
        chk("stall_rv_clear", 32'(rd_valid), 32'd0);

        // abort during the 2nd of 10 data bytes
        clear_log();
        start_read(24'h000100, 16'd10, 1'b0);
        wait_nwr(7, "abort_wr_seen");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort_done_seen");
        chk("abort_nwr", 32'(nwr), 32'd7);
        chk("abort_nrd", 32'(nrd), 32'd2);
        chk("abort_rd0", 32'(rd_log[0]), 32'h5F);
        chk("abort_rd1", 32'(rd_log[1]), 32'h66);
        chk("abort_cshi", 32'(ncsh), 32'd4);
        chk("abort_ndone", 32'(ndone), 32'd1);

        // reset during ADDR, then a clean transaction
        clear_log();
        start_read(24'h777777, 16'd2, 1'b0);
        wait_nwr(2, "rst_addr_seen");
        arstn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_format", 32'(eng_format), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_eng_wr", 32'(eng_wr), 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        repeat (5) @(negedge clk);
        clear_log();
        start_read(24'h000001, 16'd1, 1'b0);
        wait_done("post_rst_done_seen");
        chk("post_rst_nwr", 32'(nwr), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("post_rst_din%0d", i), 32'(din_log[i]), 32'(exp_rst_din[i]));
        chk("post_rst_fmt0", 32'(fmt_log[0]), 32'(3'b010));
        chk("post_rst_nrd", 32'(nrd), 32'd1);
        chk("post_rst_rd0", 32'(rd_log[0]), 32'h5F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
